fpga_transmitter: RTL and testbench

Serialises one parallel byte from a local system and ships it over the FPGA-to-FPGA link to the remote receiver. It uses the link's send/finish/acknowledge handshake. It is the sending end of the link: it drives data, send and finish, and consumes acknowledge. It also offers a simple load/ready interface to the local system, with done and error pulses.

---
 rtl/fpga_transmitter_pkg.sv | 18 +
 rtl/fpga_tx_shift_register.sv | 39 +++
 rtl/fpga_transmitter.sv | 140 ++++++++++++++
 tb/tb_fpga_transmitter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fpga_transmitter_pkg.sv
// Shared definitions for the FPGA-to-FPGA link transmitter: FSM state
// encoding, default sizing and the serial bit order agreed with the receiver.
package fpga_transmitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_FINISH  = 2'd2,
        ST_RELEASE = 2'd3
    } tx_state_t;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_ACK_TIMEOUT = 1023;

    // Link bit order; the receiver imports the same constant.
    localparam bit LINK_MSB_FIRST = 1'b1;

endpackage

// File: rtl/fpga_tx_shift_register.sv
// Parallel-load shift register that presents the next link bit on o_bit.
// Zero fill means the line idles low once every bit has been shifted out.
module fpga_tx_shift_register
    import fpga_transmitter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_bit
);

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (LINK_MSB_FIRST) begin : g_msb_first
            assign w_shifted = r_shift << 1;
            assign o_bit     = r_shift[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = r_shift >> 1;
            assign o_bit     = r_shift[0];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
        end else if (i_shift) begin
            r_shift <= w_shifted;
        end
    end

endmodule

// File: rtl/fpga_transmitter.sv
// Sending end of the FPGA-to-FPGA link: accepts a byte on load/ready, ships it
// serially with send, then holds finish until the receiver acknowledges.
module fpga_transmitter
    import fpga_transmitter_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             done,
    output logic             error,
    output logic             data,
    output logic             send,
    output logic             finish,
    input  logic             acknowledge
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    tx_state_t     r_state;
    tx_state_t     w_state_next;
    logic [BW-1:0] r_bit_cnt;
    logic [TW-1:0] r_tmo_cnt;

    logic r_ready;
    logic r_done;
    logic r_error;
    logic r_send;
    logic r_finish;
    logic w_ready_next;
    logic w_done_next;
    logic w_error_next;
    logic w_send_next;
    logic w_finish_next;

    logic w_load_accept;
    logic w_shift_en;
    logic w_ack_expired;
    logic w_data_bit;

    assign w_load_accept = (r_state == ST_IDLE) && load;
    assign w_shift_en    = (r_state == ST_SEND);
    assign w_ack_expired = (r_tmo_cnt == TMO_LAST);

    fpga_tx_shift_register #(
        .WIDTH(WIDTH)
    ) u_shift (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_load  (w_load_accept),
        .i_shift (w_shift_en),
        .i_data  (data_in),
        .o_bit   (w_data_bit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (load) w_state_next = ST_SEND;
            ST_SEND:    if (r_bit_cnt == BIT_LAST) w_state_next = ST_FINISH;
            // Acknowledge takes priority over an expiry on the same edge.
            ST_FINISH: begin
                if (acknowledge) begin
                    w_state_next = ST_RELEASE;
                end else if (w_ack_expired) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RELEASE: if (!acknowledge) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready_next  = (w_state_next == ST_IDLE);
        w_send_next   = (w_state_next == ST_SEND);
        w_finish_next = (w_state_next == ST_FINISH);
        w_done_next   = (r_state == ST_RELEASE) && !acknowledge;
        w_error_next  = (r_state == ST_FINISH) && !acknowledge && w_ack_expired;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_send   <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_ready  <= w_ready_next;
            r_done   <= w_done_next;
            r_error  <= w_error_next;
            r_send   <= w_send_next;
            r_finish <= w_finish_next;
        end
    end

    // The timeout counter only runs in FINISH and restarts on every entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bit_cnt <= '0;
            r_tmo_cnt <= '0;
        end else begin
            if (w_load_accept) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (r_state == ST_FINISH) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    assign ready  = r_ready;
    assign done   = r_done;
    assign error  = r_error;
    assign send   = r_send;
    assign finish = r_finish;
    assign data   = w_data_bit;

endmodule

// File: tb/tb_fpga_transmitter.sv
// Self-checking bench for fpga_transmitter: directed scenarios plus randomized
// frames, checked against a cycle-index model of the link handshake.
module tb_fpga_transmitter;

    localparam int W = 8;
    localparam int T = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         load = 1'b0;
    logic         acknowledge = 1'b0;
    logic         ready;
    logic         done;
    logic         error;
    logic         data;
    logic         send;
    logic         finish;

    int n_checks = 0;
    int n_pass   = 0;

    fpga_transmitter #(
        .WIDTH       (W),
        .ACK_TIMEOUT (T)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .load        (load),
        .ready       (ready),
        .done        (done),
        .error       (error),
        .data        (data),
        .send        (send),
        .finish      (finish),
        .acknowledge (acknowledge)
    );

    always #5 clock = ~clock;

    localparam logic [5:0] IDLE_OUT = 6'b100000;

    function automatic logic [5:0] observed();
        return {ready, done, error, send, finish, data};
    endfunction

    // Expected outputs in cycle c after the load edge (edge 0).
    // a = cycle in which acknowledge first rises (0: never, timeout);
    // len = cycles acknowledge stays high.
    function automatic logic [5:0] model(input logic [W-1:0] b, input int a,
                                         input int len, input int c);
        logic tmo;
        logic snd, dat, fin, dn, er, rdy;
        tmo = (a == 0);
        snd = (c >= 1 && c <= W);
        dat = snd ? b[W-c] : 1'b0;
        if (tmo) begin
            fin = (c >= W + 1 && c <= W + T);
            er  = (c == W + T + 1);
            dn  = 1'b0;
            rdy = (c >= W + T + 1);
        end else begin
            fin = (c >= W + 1 && c <= a);
            er  = 1'b0;
            dn  = (c == a + len + 1);
            rdy = (c >= a + len + 1);
        end
        return {rdy, dn, er, snd, fin, dat};
    endfunction

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b (ready,done,error,send,finish,data)",
                    tag, obs, exp);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // done/error cycle so a caller may load again immediately.
    task automatic frame(input string name, input logic [W-1:0] b, input int a,
                         input int len, input bit ack_noise, input int load_mode,
                         input logic [W-1:0] busy_val);
        int last;
        last = (a == 0) ? W + T + 1 : a + len + 1;
        load    = 1'b1;
        data_in = b;
        for (int c = 1; c <= last; c++) begin
            @(negedge clock);
            chk($sformatf("%s b=%h c%0d", name, b, c), observed(), model(b, a, len, c));
            if (c < last) begin
                case (load_mode)
                    1: begin load = 1'b1; data_in = busy_val; end
                    2: begin load = 1'($urandom_range(0, 1)); data_in = W'($urandom); end
                    default: load = 1'b0;
                endcase
            end else begin
                load = 1'b0;
            end
            if (c <= W) acknowledge = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            else acknowledge = (a != 0) && (c >= a) && (c < a + len);
        end
    endtask

    task automatic idle_gap(input string name, input int n, input bit ack_noise);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk($sformatf("%s idle%0d", name, i), observed(), IDLE_OUT);
            acknowledge = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        acknowledge = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] rb;
        int ra, rl, rgap;

        // Reset state
        repeat (2) @(negedge clock);
        chk("reset_hold", observed(), IDLE_OUT);
        reset = 1'b1;
        @(negedge clock);
        chk("post_reset", observed(), IDLE_OUT);

        // 1: ideal responder, ack follows finish by one cycle
        frame("t1_ideal", 8'hA5, W + 2, 2, 1'b0, 0, '0);
        idle_gap("t1", 1, 1'b0);

        // 2: load held during the busy phase with a different value
        frame("t2_busy", 8'h3C, W + 2, 2, 1'b0, 1, 8'hFF);
        idle_gap("t2", 1, 1'b0);

        // 3: no acknowledge -> timeout
        frame("t3_tmo", W'($urandom), 0, 0, 1'b0, 0, '0);
        idle_gap("t3", 1, 1'b0);

        // 4: acknowledge held five cycles
        frame("t4_hold", 8'h5A, W + 2, 5, 1'b0, 0, '0);
        idle_gap("t4", 1, 1'b0);

        // Boundaries: ack on the expiry edge, and ack in the first finish cycle
        frame("b_ack_at_expiry", 8'hC3, W + T, 1, 1'b0, 0, '0);
        idle_gap("b1", 1, 1'b0);
        frame("b_ack_first", 8'h96, W + 1, 1, 1'b1, 0, '0);
        idle_gap("b2", 1, 1'b0);

        // 5: asynchronous reset in the 4th send cycle
        load    = 1'b1;
        data_in = 8'hFF;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            load = 1'b0;
            chk($sformatf("t5_pre c%0d", c), observed(), model(8'hFF, W + 1, 1, c));
        end
        @(posedge clock);
        #1;
        chk("t5_send_cycle4", observed(), model(8'hFF, W + 1, 1, 4));
        #1 reset = 1'b0;
        #1;
        chk("t5_async_drop", observed(), IDLE_OUT);
        @(negedge clock);
        chk("t5_in_reset", observed(), IDLE_OUT);
        reset = 1'b1;
        @(negedge clock);
        chk("t5_released", observed(), IDLE_OUT);
        frame("t5_after", 8'h01, W + 2, 2, 1'b0, 0, '0);
        idle_gap("t5", 1, 1'b0);

        // 6: back-to-back, second load in the done cycle
        frame("t6_first", 8'h81, W + 2, 2, 1'b0, 0, '0);
        frame("t6_second", 8'h7E, W + 2, 2, 1'b0, 0, '0);
        idle_gap("t6", 1, 1'b0);

        // Randomized frames
        for (int f = 0; f < 24; f++) begin
            rb   = W'($urandom);
            ra   = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(W + 1, W + T));
            rl   = int'($urandom_range(1, 6));
            rgap = int'($urandom_range(0, 2));
            frame($sformatf("rnd%0d", f), rb, ra, rl, 1'b1,
                  int'($urandom_range(0, 2)), W'($urandom));
            idle_gap($sformatf("rnd%0d", f), rgap, 1'b1);
        end

        idle_gap("final", 1, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
